psk_mod_serial: RTL and testbench
=================================

Name: psk_mod_serial

Overview:
- Generalised BPSK/QPSK modulator for the transmit chain.
- Takes whole AXIS words (BYTES*8 bits) from the 16.384M FIFO, serialises them into symbols and holds each symbol for a runtime-programmable number of samples.
- Maps each symbol onto the carrier I/Q with Gray coding.
- Feeds the DAC interface directly. Replaces the fixed one-symbol-per-word modulator.

Parameters:
- WIDTH, 12: carrier and output sample width (signed).
- BYTES, 1: AXIS tdata width in bytes; BITS = BYTES*8, which must be even.
- SPS_W, 4: width of the samples-per-symbol control input.

Ports:
- clk_16M384  in  1  system clock.
- rst_16M384  in  1  synchronous, active-high reset.
- data_tdata  in  BITS  payload; symbols are taken LSB first.
- data_tvalid  in  1  AXIS valid.
- data_tready  out  1  AXIS ready.
- data_tlast  in  1  last word of frame.
- data_tuser  in  1  1 = BPSK, 0 = QPSK; latched per word.
- carrier_I  in  WIDTH  cos carrier, signed.
- carrier_Q  in  WIDTH  sin carrier, signed.
- SPS  in  SPS_W  samples per symbol; 0 means 2^SPS_W; sampled at each symbol start.
- out_I, out_Q  out  WIDTH  modulated samples, signed.
- out_vld  out  1  sample valid.
- out_last  out  1  high for all samples of the final symbol of a tlast word.
- out_is_bpsk  out  1  mode of the current symbol.
- out_bits  out  2  raw symbol bits (BPSK: {1'b0,b}).
- out_sym_start  out  1  one-cycle pulse on the first sample of each symbol.
- out_underrun  out  1  one-cycle pulse when a non-last word ends with no next word available.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Counters, shift register and phase index are cleared. A reset mid-word drops the remainder of that word.
- FSM states are IDLE and SEND.
- IDLE:
  - data_tready = 1.
  - On tvalid&&tready: latch tdata into shreg, latch tuser and tlast, set sym_cnt=0, set samp_cnt=0, go to SEND.
- SEND:
  - samp_cnt counts 0..SPS_eff-1, where SPS_eff is latched at samp_cnt==0.
  - At the end of a symbol (samp_cnt==SPS_eff-1), shreg shifts right by 1 (BPSK) or 2 (QPSK) and sym_cnt increments.
  - A word holds N = BITS symbols (BPSK) or BITS/2 symbols (QPSK).
- data_tready is combinationally 1 in IDLE, and in SEND only on the final sample of the final symbol. This gives back-to-back words with no gap.
  - Handshake at the final sample: load the next word and stay in SEND.
  - No handshake at the final sample: go to IDLE.
  - If the finished word had no tlast, pulse out_underrun. A tlast word never raises underrun.
- Symbol bits:
  - BPSK b = shreg[0].
  - QPSK {bI,bQ} = shreg[1:0] (bit1 = I).
- Phase index p (2 bits), Gray mapping:
  - QPSK: 00→0, 10→1, 11→2, 01→3.
  - BPSK: 0→0, 1→2.
- Carrier set: c0=I, c1=Q, c2=-I, c3=-Q.
- Output: out_I = c[p], out_Q = c[p+1 mod 4].
- Negation saturates: -(-2^(WIDTH-1)) gives 2^(WIDTH-1)-1.
- Outputs are registered with 1 cycle latency from carrier/FSM state. Carriers track sample by sample within a symbol.
- In IDLE, out_I = out_Q = 0 and out_vld = 0.
- SPS is only sampled at symbol start. A change mid-symbol takes effect from the next symbol.

Optional Feature:
- Macro: PSK_MOD_DIFF_EN, enabling differential encoding (DBPSK/DQPSK).
- With the macro:
  - p_acc ← p_acc + p_map (mod 4) at each symbol start, and the output uses p_acc.
  - p_acc resets to 0 on reset and after the final symbol of a tlast word.
  - p_acc persists across non-last words and across underrun.
- Without the macro: p = p_map directly and no accumulator is built.

Decomposition:
- Package psk_pkg holds:
  - phase_idx_t (2-bit).
  - FSM state enum {IDLE, SEND}.
  - Gray-to-index constants for QPSK and BPSK.
  - the saturating-negate function.
- Sub-module psk_phase_sel: combinational, takes (carrier_I, carrier_Q, p) and returns (I, Q) with saturation. It is reused by the receiver's reference generator.

Test Plan:
- QPSK, SPS=4, BYTES=1, one word 8'b01_11_10_00 with tlast:
  - 4 symbols, p = 0,1,2,3.
  - out_vld high for 16 cycles; out_sym_start at samples 0,4,8,12.
  - out_last high for samples 12–15; no underrun.
- BPSK, SPS=2, word 8'hA5 followed immediately by 8'h0F with tlast:
  - 16 symbols, 32 contiguous valid samples.
  - tready high exactly once at sample 15; no gap and no underrun.
- Underrun, QPSK, one word without tlast and tvalid held low afterward:
  - out_underrun pulses once after the 4th symbol.
  - FSM returns to IDLE; outputs go to 0.
- Saturation, carrier_I = -2048 (WIDTH=12), symbol 11 → out_I = 2047.
- Reset asserted on sample 5 of an active word:
  - next cycle, all outputs are 0 and tready is 1.
  - a following word starts cleanly.
- PSK_MOD_DIFF_EN, QPSK symbols 10,10,10 → p_acc = 1,2,3; after a tlast word the next frame starts at p = 0.

Source files
------------

// File: rtl/psk_pkg.sv
// psk_pkg: shared types, Gray-to-phase constants and the saturating negate
// used by the PSK modulator and by the receiver's reference generator.
package psk_pkg;

    // Index into the four-entry carrier set {I, Q, -I, -Q}
    typedef logic [1:0] phase_idx_t;

    // Modulator control states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } psk_state_t;

    // QPSK Gray mapping, symbol bits {bI,bQ} -> phase index
    localparam phase_idx_t QPSK_P_00 = 2'd0;
    localparam phase_idx_t QPSK_P_10 = 2'd1;
    localparam phase_idx_t QPSK_P_11 = 2'd2;
    localparam phase_idx_t QPSK_P_01 = 2'd3;

    // BPSK mapping, symbol bit b -> phase index
    localparam phase_idx_t BPSK_P_0 = 2'd0;
    localparam phase_idx_t BPSK_P_1 = 2'd2;

    // Map raw symbol bits onto a phase index; BPSK looks only at bit 0
    function automatic phase_idx_t gray_to_phase(input logic [1:0] bits,
                                                 input logic       is_bpsk);
        phase_idx_t p;
        p = QPSK_P_00;
        if (is_bpsk) begin
            p = bits[0] ? BPSK_P_1 : BPSK_P_0;
        end else begin
            case (bits)
                2'b00:   p = QPSK_P_00;
                2'b10:   p = QPSK_P_10;
                2'b11:   p = QPSK_P_11;
                default: p = QPSK_P_01;
            endcase
        end
        return p;
    endfunction

    // Negate a w-bit signed value held sign-extended in 32 bits; the most
    // negative code would overflow, so it clamps to the most positive code.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                   input int                 w);
        logic signed [31:0] minVal;
        minVal = -(32'sd1 <<< (w - 1));
        if (x == minVal) begin
            return -(minVal + 32'sd1);
        end
        return -x;
    endfunction

endpackage

// File: rtl/psk_phase_sel.sv
// psk_phase_sel: picks the output I/Q pair from the carrier set
// {I, Q, -I, -Q} for a given phase index. out_I = c[p], out_Q = c[p+1].
// Purely combinational so it can also serve the receiver's reference path.
module psk_phase_sel
    import psk_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH-1:0] i_carrier_I,
    input  logic signed [WIDTH-1:0] i_carrier_Q,
    input  phase_idx_t              i_phase,
    output logic signed [WIDTH-1:0] o_I,
    output logic signed [WIDTH-1:0] o_Q
);

    logic signed [WIDTH-1:0] w_neg_I;
    logic signed [WIDTH-1:0] w_neg_Q;

    assign w_neg_I = WIDTH'(sat_neg(32'(i_carrier_I), WIDTH));
    assign w_neg_Q = WIDTH'(sat_neg(32'(i_carrier_Q), WIDTH));

    // Rotate through the carrier set by the requested quarter-turns
    always_comb begin
        o_I = i_carrier_I;
        o_Q = i_carrier_Q;
        case (i_phase)
            2'd0: begin o_I = i_carrier_I; o_Q = i_carrier_Q; end
            2'd1: begin o_I = i_carrier_Q; o_Q = w_neg_I;     end
            2'd2: begin o_I = w_neg_I;     o_Q = w_neg_Q;     end
            default: begin o_I = w_neg_Q;  o_Q = i_carrier_I; end
        endcase
    end

endmodule

// File: rtl/psk_mod_serial.sv
// psk_mod_serial: serialising BPSK/QPSK modulator. Whole AXIS words are
// split LSB first into symbols, each held for SPS samples, Gray mapped and
// rotated onto the incoming carrier. Words chain back to back when the next
// one is offered on the last sample of the current word.
// Optional build macro PSK_MOD_DIFF_EN adds differential (DBPSK/DQPSK)
// encoding through a phase accumulator.
module psk_mod_serial
    import psk_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int BYTES = 1,
    parameter int SPS_W = 4
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic [BYTES*8-1:0]      data_tdata,
    input  logic                    data_tvalid,
    output logic                    data_tready,
    input  logic                    data_tlast,
    input  logic                    data_tuser,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    input  logic [SPS_W-1:0]        SPS,
    output logic signed [WIDTH-1:0] out_I,
    output logic signed [WIDTH-1:0] out_Q,
    output logic                    out_vld,
    output logic                    out_last,
    output logic                    out_is_bpsk,
    output logic [1:0]              out_bits,
    output logic                    out_sym_start,
    output logic                    out_underrun
);

    localparam int BITS  = BYTES * 8;
    localparam int SYM_W = $clog2(BITS);
    localparam int CNT_W = SPS_W + 1;

    psk_state_t              r_state;
    logic [BITS-1:0]         r_shreg;
    logic                    r_is_bpsk;
    logic                    r_last;
    logic [SYM_W-1:0]        r_sym_cnt;
    logic [CNT_W-1:0]        r_samp_cnt;
    logic [CNT_W-1:0]        r_sps_eff;

    logic signed [WIDTH-1:0] r_out_I;
    logic signed [WIDTH-1:0] r_out_Q;
    logic                    r_out_vld;
    logic                    r_out_last;
    logic                    r_out_is_bpsk;
    logic [1:0]              r_out_bits;
    logic                    r_out_sym_start;
    logic                    r_out_underrun;

    logic [CNT_W-1:0]        w_sps_in;
    logic [CNT_W-1:0]        w_sps_cur;
    logic                    w_sym_start;
    logic                    w_sym_end;
    logic                    w_last_sym;
    logic                    w_word_end;
    logic                    w_tready;
    logic                    w_load;
    logic [1:0]              w_sym_bits;
    phase_idx_t              w_p_map;
    phase_idx_t              w_p;
    logic signed [WIDTH-1:0] w_sel_I;
    logic signed [WIDTH-1:0] w_sel_Q;

    // A zero SPS code stands for the full 2^SPS_W samples per symbol. On the
    // first sample of a symbol the live input decides the symbol length, so
    // even a one-sample symbol ends on time; later samples use the latch.
    assign w_sps_in    = (SPS == '0) ? CNT_W'(1 << SPS_W) : CNT_W'(SPS);
    assign w_sym_start = (r_samp_cnt == '0);
    assign w_sps_cur   = w_sym_start ? w_sps_in : r_sps_eff;
    assign w_sym_end   = (r_samp_cnt == w_sps_cur - CNT_W'(1));
    assign w_last_sym  = r_is_bpsk ? (r_sym_cnt == SYM_W'(BITS - 1))
                                   : (r_sym_cnt == SYM_W'(BITS / 2 - 1));
    assign w_word_end  = (r_state == SEND) && w_sym_end && w_last_sym;

    // Ready only when idle or on the very last sample of a word, so a word
    // offered at that moment follows with no gap.
    assign w_tready    = (r_state == IDLE) || w_word_end;
    assign w_load      = data_tvalid && w_tready;
    assign data_tready = w_tready;

    assign w_sym_bits  = r_is_bpsk ? {1'b0, r_shreg[0]} : r_shreg[1:0];
    assign w_p_map     = gray_to_phase(r_shreg[1:0], r_is_bpsk);

`ifdef PSK_MOD_DIFF_EN
    phase_idx_t r_p_acc;

    // Each new symbol advances the running phase; samples inside a symbol
    // keep the phase reached at its start.
    assign w_p = w_sym_start ? phase_idx_t'(r_p_acc + w_p_map) : r_p_acc;

    // Running phase persists across plain word boundaries and underruns,
    // and restarts at zero once a frame's final symbol is done.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            r_p_acc <= '0;
        end else if (r_state == SEND) begin
            if (w_word_end && r_last) begin
                r_p_acc <= '0;
            end else if (w_sym_start) begin
                r_p_acc <= w_p;
            end
        end
    end
`else
    assign w_p = w_p_map;
`endif

    psk_phase_sel #(
        .WIDTH(WIDTH)
    ) u_phase_sel (
        .i_carrier_I(carrier_I),
        .i_carrier_Q(carrier_Q),
        .i_phase    (w_p),
        .o_I        (w_sel_I),
        .o_Q        (w_sel_Q)
    );

    // Word loading, symbol timing and shifting; a reset drops any word
    // still in flight.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_is_bpsk  <= 1'b0;
            r_last     <= 1'b0;
            r_sym_cnt  <= '0;
            r_samp_cnt <= '0;
            r_sps_eff  <= '0;
        end else begin
            if (r_state == SEND && w_sym_start) begin
                r_sps_eff <= w_sps_in;
            end
            if (w_load) begin
                r_shreg    <= data_tdata;
                r_is_bpsk  <= data_tuser;
                r_last     <= data_tlast;
                r_sym_cnt  <= '0;
                r_samp_cnt <= '0;
                r_state    <= SEND;
            end else if (r_state == SEND) begin
                if (w_word_end) begin
                    r_sym_cnt  <= '0;
                    r_samp_cnt <= '0;
                    r_state    <= IDLE;
                end else if (w_sym_end) begin
                    r_shreg    <= r_is_bpsk ? (r_shreg >> 1) : (r_shreg >> 2);
                    r_sym_cnt  <= r_sym_cnt + SYM_W'(1);
                    r_samp_cnt <= '0;
                end else begin
                    r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Registered sample outputs; everything is forced to zero while idle.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384 || r_state != SEND) begin
            r_out_I         <= '0;
            r_out_Q         <= '0;
            r_out_vld       <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_is_bpsk   <= 1'b0;
            r_out_bits      <= 2'b00;
            r_out_sym_start <= 1'b0;
            r_out_underrun  <= 1'b0;
        end else begin
            r_out_I         <= w_sel_I;
            r_out_Q         <= w_sel_Q;
            r_out_vld       <= 1'b1;
            r_out_last      <= r_last && w_last_sym;
            r_out_is_bpsk   <= r_is_bpsk;
            r_out_bits      <= w_sym_bits;
            r_out_sym_start <= w_sym_start;
            r_out_underrun  <= w_word_end && !w_load && !r_last;
        end
    end

    assign out_I         = r_out_I;
    assign out_Q         = r_out_Q;
    assign out_vld       = r_out_vld;
    assign out_last      = r_out_last;
    assign out_is_bpsk   = r_out_is_bpsk;
    assign out_bits      = r_out_bits;
    assign out_sym_start = r_out_sym_start;
    assign out_underrun  = r_out_underrun;

endmodule

// File: tb/tb_psk_mod_serial.sv
// tb_psk_mod_serial: drives words, SPS and a randomly moving carrier into
// psk_mod_serial and compares every output against a symbol-queue model of
// the modulator, plus a few directed frame-level counts.
module tb_psk_mod_serial;

    localparam int WIDTH = 12;
    localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam int MINV  = -(1 << (WIDTH - 1));

    typedef struct packed {
        logic [1:0] bits;
        logic       bpsk;
        logic       wordEnd;
        logic       wordLast;
    } sym_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [7:0]              dataTdata;
    logic                    dataTvalid;
    logic                    dataTready;
    logic                    dataTlast;
    logic                    dataTuser;
    logic signed [WIDTH-1:0] carI;
    logic signed [WIDTH-1:0] carQ;
    logic [3:0]              sps;
    logic signed [WIDTH-1:0] outI;
    logic signed [WIDTH-1:0] outQ;
    logic                    outVld;
    logic                    outLast;
    logic                    outIsBpsk;
    logic [1:0]              outBits;
    logic                    outSymStart;
    logic                    outUnderrun;

    int testsRun    = 0;
    int testsFailed = 0;

    sym_t symQ[$];
    sym_t cur;
    int   curRemain = 0;
    int   pAcc      = 0;
    bit   lastHs    = 0;
    bit   started   = 0;
    bit   holdCar   = 0;
    bit   spsJitter = 0;

    int         eI, eQ;
    bit         eVld, eLast, eBpsk, eStart, eUnder;
    logic [1:0] eBits;

    int cntVld, cntStart, cntLast, cntUnder, cntSat, cntNeg50;

    psk_mod_serial #(
        .WIDTH(WIDTH),
        .BYTES(1),
        .SPS_W(4)
    ) dut (
        .clk_16M384   (clk),
        .rst_16M384   (reset),
        .data_tdata   (dataTdata),
        .data_tvalid  (dataTvalid),
        .data_tready  (dataTready),
        .data_tlast   (dataTlast),
        .data_tuser   (dataTuser),
        .carrier_I    (carI),
        .carrier_Q    (carQ),
        .SPS          (sps),
        .out_I        (outI),
        .out_Q        (outQ),
        .out_vld      (outVld),
        .out_last     (outLast),
        .out_is_bpsk  (outIsBpsk),
        .out_bits     (outBits),
        .out_sym_start(outSymStart),
        .out_underrun (outUnderrun)
    );

    // Free-running 16.384 MHz-style system clock
    always #5 clk = ~clk;

    // Hard stop in case the bench itself wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag,
                               input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d", tag, observed, expected);
        end
    endtask

    function automatic int satNeg(input int x);
        return (x == MINV) ? MAXV : -x;
    endfunction

    function automatic int spsEff(input logic [3:0] s);
        return (s == 4'd0) ? 16 : int'(s);
    endfunction

    function automatic int phaseOf(input sym_t s);
        if (s.bpsk) return s.bits[0] ? 2 : 0;
        case (s.bits)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Ready when nothing is in flight, or the coming edge closes a word
    function automatic bit modelReady();
        if (curRemain == 0 && symQ.size() == 0) return 1'b1;
        if (curRemain == 1 && cur.wordEnd) return 1'b1;
        if (curRemain == 0 && symQ.size() > 0 && symQ[0].wordEnd && spsEff(sps) == 1)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic pushWord(input logic [7:0] d, input logic bpsk, input logic last);
        sym_t s;
        if (bpsk) begin
            for (int i = 0; i < 8; i++) begin
                s.bits = {1'b0, d[i]};
                s.bpsk = 1'b1;
                s.wordEnd = (i == 7);
                s.wordLast = last;
                symQ.push_back(s);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                s.bits = d[2*i +: 2];
                s.bpsk = 1'b0;
                s.wordEnd = (i == 3);
                s.wordLast = last;
                symQ.push_back(s);
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelStep();
        bit hs;
        int p;
        int c[4];
        eVld = 0; eI = 0; eQ = 0; eLast = 0; eBpsk = 0; eBits = 2'b00;
        eStart = 0; eUnder = 0;
        if (reset) begin
            symQ.delete();
            curRemain = 0;
            pAcc = 0;
            lastHs = 0;
            return;
        end
        hs = dataTvalid && modelReady();
        if (curRemain == 0 && symQ.size() > 0) begin
            cur = symQ.pop_front();
            curRemain = spsEff(sps);
            eStart = 1;
            pAcc = (pAcc + phaseOf(cur)) % 4;
        end
        if (curRemain > 0) begin
`ifdef PSK_MOD_DIFF_EN
            p = pAcc;
`else
            p = phaseOf(cur);
`endif
            c[0] = int'(carI);
            c[1] = int'(carQ);
            c[2] = satNeg(c[0]);
            c[3] = satNeg(c[1]);
            eI = c[p];
            eQ = c[(p + 1) % 4];
            eVld = 1;
            eLast = cur.wordEnd && cur.wordLast;
            eBpsk = cur.bpsk;
            eBits = cur.bits;
            curRemain--;
            if (curRemain == 0 && cur.wordEnd) begin
                if (!cur.wordLast && !hs) eUnder = 1;
                if (cur.wordLast) pAcc = 0;
            end
        end
        if (hs) pushWord(dataTdata, dataTuser, dataTlast);
        lastHs = hs;
    endtask

    // One clock: check outputs mid-cycle, step the model at the edge, then
    // move the carrier (and maybe SPS) just after the edge.
    task automatic tick();
        @(negedge clk);
        if (started) begin
            checkOutput("out_vld", outVld, eVld);
            checkOutput("out_I", outI, eI);
            checkOutput("out_Q", outQ, eQ);
            checkOutput("out_last", outLast, eLast);
            checkOutput("out_is_bpsk", outIsBpsk, eBpsk);
            checkOutput("out_bits", outBits, eBits);
            checkOutput("out_sym_start", outSymStart, eStart);
            checkOutput("out_underrun", outUnderrun, eUnder);
            checkOutput("data_tready", dataTready, modelReady());
            cntVld   += int'(outVld);
            cntStart += int'(outSymStart);
            cntLast  += int'(outLast);
            cntUnder += int'(outUnderrun);
            if (outVld && outI == 12'sd2047) cntSat++;
            if (outVld && outI == -12'sd50) cntNeg50++;
        end
        @(posedge clk);
        modelStep();
        started = 1;
        #1;
        if (!holdCar) begin
            carI = ($urandom_range(0, 9) == 0) ? 12'sh800 : 12'($urandom);
            carQ = ($urandom_range(0, 9) == 0) ? 12'sh800 : 12'($urandom);
        end
        if (spsJitter && $urandom_range(0, 19) == 0) sps = 4'($urandom);
    endtask

    task automatic clearCounts();
        cntVld = 0; cntStart = 0; cntLast = 0; cntUnder = 0; cntSat = 0; cntNeg50 = 0;
    endtask

    // Offer one word, hold it until accepted, then idle the bus for gap cycles
    task automatic applyStimulus(input logic [7:0] d, input logic bpsk,
                                 input logic last, input int gap);
        int n;
        dataTdata  = d;
        dataTuser  = bpsk;
        dataTlast  = last;
        dataTvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!lastHs && n < 400);
        checkOutput("handshake", lastHs, 1);
        dataTvalid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(curRemain == 0 && symQ.size() == 0) && n < 400) begin
            tick();
            n++;
        end
        tick();
        checkOutput("idle_tready", dataTready, 1);
    endtask

    initial begin
        reset = 1'b1; dataTdata = 8'h00; dataTvalid = 1'b0; dataTlast = 1'b0;
        dataTuser = 1'b0; carI = 12'sd300; carQ = -12'sd700; sps = 4'd4;
        clearCounts();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_tready", dataTready, 1);
        checkOutput("reset_vld", outVld, 0);

        // QPSK frame, four symbols of four samples, phases 0..3
        clearCounts();
        applyStimulus(8'b01_11_10_00, 1'b0, 1'b1, 0);
        waitIdle();
        checkOutput("t1_vld_count", cntVld, 16);
        checkOutput("t1_start_count", cntStart, 4);
        checkOutput("t1_last_count", cntLast, 4);
        checkOutput("t1_underrun_count", cntUnder, 0);

        // BPSK, two words chained back to back
        clearCounts();
        sps = 4'd2;
        applyStimulus(8'hA5, 1'b1, 1'b0, 0);
        applyStimulus(8'h0F, 1'b1, 1'b1, 0);
        waitIdle();
        checkOutput("t2_vld_count", cntVld, 32);
        checkOutput("t2_start_count", cntStart, 16);
        checkOutput("t2_underrun_count", cntUnder, 0);

        // Non-last word with nothing behind it
        clearCounts();
        sps = 4'd4;
        applyStimulus(8'h6C, 1'b0, 1'b0, 0);
        waitIdle();
        checkOutput("t3_underrun_count", cntUnder, 1);
        checkOutput("t3_vld_after", outVld, 0);

        // Saturating negate of the most negative carrier value
        clearCounts();
        holdCar = 1; carI = 12'sh800; carQ = 12'sd5; sps = 4'd1;
        applyStimulus(8'hFF, 1'b0, 1'b1, 0);
        waitIdle();
`ifdef PSK_MOD_DIFF_EN
        checkOutput("t4_sat_count", cntSat, 2);
`else
        checkOutput("t4_sat_count", cntSat, 4);
`endif
        holdCar = 0;

        // Reset in the middle of a word, then a clean restart
        sps = 4'd4;
        applyStimulus(8'h93, 1'b0, 1'b0, 0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t5_tready", dataTready, 1);
        checkOutput("t5_vld", outVld, 0);
        checkOutput("t5_I", outI, 0);
        applyStimulus(8'h1B, 1'b0, 1'b1, 0);
        waitIdle();

`ifdef PSK_MOD_DIFF_EN
        // Differential: symbols 10,10,10,00 reach phase 3 twice per frame
        clearCounts();
        holdCar = 1; carI = 12'sd100; carQ = 12'sd50; sps = 4'd2;
        applyStimulus(8'h2A, 1'b0, 1'b1, 0);
        applyStimulus(8'h2A, 1'b0, 1'b1, 0);
        waitIdle();
        checkOutput("t6_phase3_count", cntNeg50, 8);
        holdCar = 0;
`endif

        // Randomised words, modes, gaps and SPS changes
        spsJitter = 1;
        for (int w = 0; w < 40; w++) begin
            int sel;
            int gap;
            sel = $urandom_range(0, 3);
            gap = (sel == 1) ? $urandom_range(1, 4) :
                  (sel == 3) ? $urandom_range(20, 150) : 0;
            applyStimulus(8'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 3), gap);
        end
        spsJitter = 0;
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
